prog_loader: RTL
================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, meaning word-address width of the instruction memory (depth 2^ADDR_W 32-bit words).
REQ-002 SHALL have parameter HDR_BYTE, default 8'hA5, meaning the frame start byte.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rx_data  input  8  host byte (driven from ui_in).
REQ-006 SHALL have port rx_valid  input  1  host byte present.
REQ-007 SHALL have port rx_ready  output  1  loader can accept a byte; transfer when rx_valid&&rx_ready.
REQ-008 SHALL have port mem_we  output  1  one-cycle instruction-memory write strobe.
REQ-009 SHALL have port mem_addr  output  ADDR_W  word write address.
REQ-010 SHALL have port mem_wdata  output  32  assembled instruction word.
REQ-011 SHALL have port core_rst_n  output  1  active-low reset to the processor core.
REQ-012 SHALL have port busy  output  1  frame in progress.
REQ-013 SHALL have port done  output  1  last frame loaded successfully.
REQ-014 SHALL have port err  output  1  last frame rejected.

Function
REQ-015 SHALL implement FSM states IDLE, LEN, DATA, WRITE, CHK, DONE, ERR.
REQ-016 SHALL, in IDLE/DONE/ERR, move to LEN on an accepted byte equal to HDR_BYTE and discard any other byte.
REQ-017 SHALL, in LEN, capture N=rx_data; N=0 or N>2^ADDR_W -> ERR; else DATA with word count and mem_addr cleared.
REQ-018 SHALL assemble each word from 4 accepted bytes, little-endian (first byte -> bits 7:0).
REQ-019 SHALL enter WRITE after the 4th byte, assert mem_we exactly one cycle with current mem_addr/mem_wdata, deassert rx_ready that cycle, then increment mem_addr.
REQ-020 SHALL, after word N is written, go to CHK (macro defined) or DONE (macro undefined).
REQ-021 SHALL drive rx_ready=1 in every state except WRITE.
REQ-022 SHALL hold core_rst_n=0 in IDLE, LEN, DATA, WRITE, CHK, ERR and drive core_rst_n=1 only in DONE.
REQ-023 SHALL drive busy=1 in LEN, DATA, WRITE, CHK; done=1 only in DONE; err=1 only in ERR.
REQ-024 SHALL treat a HDR_BYTE received in DATA as data, not a restart.
REQ-025 SHALL, on re-entry to LEN from DONE, reassert core reset in the same cycle the header is accepted's next state.
REQ-026 SHALL ignore rx_valid when rx_ready=0; the host holds the byte until accepted.
REQ-027 SHALL accept N=2^ADDR_W (64) with last write at mem_addr=63 and no address wrap.

Reset
REQ-028 SHALL on rst_n=0 asynchronously force IDLE, rx_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, core_rst_n=0, busy=0, done=0, err=0, byte/word counters and checksum=0.
REQ-029 SHALL abandon any partial frame on reset mid-operation; already-written words are not rolled back.

Configuration
REQ-030 SHALL support macro PROG_LOADER_CHKSUM_EN: defined -> after the last word, one checksum byte is accepted in CHK; equal to XOR of all 4N data bytes -> DONE, else ERR.
REQ-031 SHALL, with PROG_LOADER_CHKSUM_EN undefined, omit CHK state and checksum register; frame ends after the last WRITE.

Structure
REQ-032 SHALL place the FSM state enum, HDR_BYTE default and 32-bit word width constant in shared package prog_loader_pkg.
REQ-033 SHALL keep byte-to-word assembly in sub-module byte_packer (4-byte shift register with count and word_valid); everything else flat.

Verification
REQ-034 SHALL verify: A5,01,13,00,00,00 (+chk 13 if macro) -> one mem_we, addr 0, wdata 32'h00000013, then done=1, core_rst_n=1.
REQ-035 SHALL verify: A5,00 -> err=1, no mem_we, core_rst_n=0; then A5,01,4 bytes(+chk) -> done=1.
REQ-036 SHALL verify: A5,41 (65 > 64) -> err=1; A5,40 + 256 bytes -> 64 writes, last addr 63, done=1.
REQ-037 SHALL verify (macro on): A5,01,EF,BE,AD,DE,checksum 00 -> err=1 (expected 8'h22), word 32'hDEADBEEF still written at addr 0.
REQ-038 SHALL verify: rx_valid held high continuously -> rx_ready low exactly one cycle per word, no byte lost or duplicated.
REQ-039 SHALL verify: rst_n pulsed low after 2 data bytes -> all outputs at reset values immediately; following frame loads at addr 0.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg -- shared definitions for the program loader.
//   HDR_BYTE_DEF : default frame start byte
//   WORD_W       : instruction word width
//   state_t      : loader FSM state encoding
// Optional feature macro: PROG_LOADER_CHKSUM_EN (adds the CHK state).
package prog_loader_pkg;

  localparam logic [7:0]  HDR_BYTE_DEF = 8'hA5;
  localparam int unsigned WORD_W       = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_WRITE,
`ifdef PROG_LOADER_CHKSUM_EN
    ST_CHK,
`endif
    ST_DONE,
    ST_ERR
  } state_t;

endpackage

// File: rtl/byte_packer.sv
// byte_packer -- assembles 32-bit words from 4 bytes, little-endian.
//   clk, rst_n     : clock, async active-low reset
//   i_clr          : restart byte count (new frame)
//   i_valid/i_byte : accepted byte strobe and value
//   o_word         : shift register contents (full word after 4th byte)
//   o_word_valid   : high in the cycle the 4th byte of a word is accepted
module byte_packer
  import prog_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_valid,
  input  logic [7:0]        i_byte,
  output logic [WORD_W-1:0] o_word,
  output logic              o_word_valid
);

  logic [WORD_W-1:0] r_word;
  logic [1:0]        r_cnt;

  // New bytes enter at the top; after four shifts the first byte sits in [7:0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word <= '0;
      r_cnt  <= '0;
    end else if (i_clr) begin
      r_cnt  <= '0;
    end else if (i_valid) begin
      r_word <= {i_byte, r_word[WORD_W-1:8]};
      r_cnt  <= r_cnt + 2'd1;
    end
  end

  always_comb begin
    o_word       = r_word;
    o_word_valid = i_valid && !i_clr && (r_cnt == 2'd3);
  end

endmodule

// File: rtl/prog_loader.sv
// prog_loader -- receives a framed program from a host byte stream and
// writes it into instruction memory while holding the core in reset.
// Frame: HDR_BYTE, N (word count 1..2^ADDR_W), 4*N data bytes LSB first,
// plus one XOR checksum byte when PROG_LOADER_CHKSUM_EN is defined.
//   clk, rst_n          : clock, async active-low reset
//   rx_data/rx_valid    : host byte and its valid flag
//   rx_ready            : byte accepted when rx_valid && rx_ready
//   mem_we/addr/wdata   : one-cycle instruction memory write port
//   core_rst_n          : core reset, released only after a good frame
//   busy/done/err       : frame in progress / loaded / rejected
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_W   = 6,
  parameter logic [7:0]  HDR_BYTE = HDR_BYTE_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              core_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned LEN_W = ADDR_W + 1;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  state_t             r_state;
  state_t             w_next;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_wcnt;
  logic [ADDR_W-1:0]  r_addr;
`ifdef PROG_LOADER_CHKSUM_EN
  logic [7:0]         r_chk;
`endif

  logic               w_accept;
  logic               w_len_bad;
  logic               w_last;
  logic               w_word_valid;
  logic [WORD_W-1:0]  w_word;

  always_comb begin
    w_accept  = rx_valid && rx_ready;
    w_len_bad = (rx_data == 8'd0) || (32'(rx_data) > DEPTH);
    w_last    = (r_wcnt + LEN_W'(1)) == r_len;
  end

  byte_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clr        (r_state == ST_LEN),
    .i_valid      (w_accept && (r_state == ST_DATA)),
    .i_byte       (rx_data),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERR:
        if (w_accept && (rx_data == HDR_BYTE)) w_next = ST_LEN;
      ST_LEN:
        if (w_accept) w_next = w_len_bad ? ST_ERR : ST_DATA;
      ST_DATA:
        if (w_word_valid) w_next = ST_WRITE;
      ST_WRITE:
`ifdef PROG_LOADER_CHKSUM_EN
        w_next = w_last ? ST_CHK : ST_DATA;
      ST_CHK:
        if (w_accept) w_next = (rx_data == r_chk) ? ST_DONE : ST_ERR;
`else
        w_next = w_last ? ST_DONE : ST_DATA;
`endif
      default:
        w_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from state only
  always_comb begin
    rx_ready   = 1'b1;
    mem_we     = 1'b0;
    core_rst_n = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    case (r_state)
      ST_LEN, ST_DATA: busy = 1'b1;
      ST_WRITE: begin
        busy     = 1'b1;
        rx_ready = 1'b0;
        mem_we   = 1'b1;
      end
`ifdef PROG_LOADER_CHKSUM_EN
      ST_CHK:   busy = 1'b1;
`endif
      ST_DONE: begin
        done       = 1'b1;
        core_rst_n = 1'b1;
      end
      ST_ERR:   err = 1'b1;
      default: ;
    endcase
  end

  // Frame datapath: length, word count, write address, checksum.
  // The address is not advanced after the final word so a full-depth
  // frame leaves mem_addr at the top entry instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len  <= '0;
      r_wcnt <= '0;
      r_addr <= '0;
`ifdef PROG_LOADER_CHKSUM_EN
      r_chk  <= '0;
`endif
    end else begin
      case (r_state)
        ST_LEN:
          if (w_accept) begin
            r_len  <= LEN_W'(rx_data);
            r_wcnt <= '0;
            r_addr <= '0;
`ifdef PROG_LOADER_CHKSUM_EN
            r_chk  <= '0;
`endif
          end
`ifdef PROG_LOADER_CHKSUM_EN
        ST_DATA:
          if (w_accept) r_chk <= r_chk ^ rx_data;
`endif
        ST_WRITE: begin
          r_wcnt <= r_wcnt + LEN_W'(1);
          if (!w_last) r_addr <= r_addr + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_addr  = r_addr;
    mem_wdata = w_word;
  end

endmodule
